// File: rtl/d_reg_pipe_pkg.sv
// Shared constants and helpers for the d_reg_pipe delay line.
// Holds the occupancy-counter width function and the minimum legal depth.
package d_reg_pkg;

    localparam int DEPTH_MIN = 1;

    // Counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_reg_pipe_if.sv
// Bus bundle for d_reg_pipe: input side (en/flush/valid/data) and output side
// (last-stage valid/data plus occupancy count). No back-pressure; en stalls everything.
interface d_reg_pipe_if
    import d_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);

    logic                      en;
    logic                      flush;
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [cnt_w(DEPTH)-1:0]   count;

    modport master (
        output en, flush, in_valid, in_data,
        input  out_valid, out_data, count
    );

    modport slave (
        input  en, flush, in_valid, in_data,
        output out_valid, out_data, count
    );

endinterface

// File: rtl/d_reg_pipe_stage.sv
// One data+valid stage of the delay line. Valid bit always resets; the data
// register only resets when D_REG_PIPE_DATA_RST_EN is defined.
module d_reg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_i;
        end
    end

`ifdef D_REG_PIPE_DATA_RST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en && !flush) begin
            data_q <= data_i;
        end
    end
`else
    // Enable-only flop: flush leaves data untouched, bubbles still load.
    always_ff @(posedge clk) begin
        if (en && !flush && !rst) begin
            data_q <= data_i;
        end
    end
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/d_reg_pipe.sv
// WIDTH-bit, DEPTH-stage retiming chain with valid tracking, stall, flush and
// live occupancy count. Optional data reset via D_REG_PIPE_DATA_RST_EN.
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    d_reg_pipe_if.slave  bus
);

    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < DEPTH_MIN) begin : g_depth_chk
        $error("d_reg_pipe: DEPTH=%0d is below the minimum of %0d", DEPTH, DEPTH_MIN);
    end

    // Index 0 is the chain input; index i+1 is the output of stage i.
    logic [DEPTH:0]   valid_w;
    logic [WIDTH-1:0] data_w [DEPTH+1];

    assign valid_w[0] = bus.in_valid;
    assign data_w[0]  = bus.in_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        d_reg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .flush   (bus.flush),
            .valid_i (valid_w[i]),
            .data_i  (data_w[i]),
            .valid_o (valid_w[i+1]),
            .data_o  (data_w[i+1])
        );
    end

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A full chain can only accept while its last item leaves, so no overflow.
    always_comb begin
        count_d = count_q;
        if (bus.en) begin
            count_d = count_q + CW'(bus.in_valid) - CW'(valid_w[DEPTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out_valid = valid_w[DEPTH];
    assign bus.out_data  = data_w[DEPTH];
    assign bus.count     = count_q;

endmodule
